pixel_pattern_source: RTL and testbench

PIXEL_PATTERN_SOURCE -- requirements
Module: pixel_pattern_source

---
 rtl/pixel_pattern_source.sv | 202 ++++++++++++++++++++
 tb/tb_pixel_pattern_source.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pattern_source.sv
// Streaming RGB565 test-pattern source (solid / colour bars / checkerboard) with ready/valid handshake.
// Define PIXEL_PATTERN_ANIMATE_EN to scroll patterns 1 and 2 horizontally by one pixel per frame.
module pixel_pattern_source #(
   parameter int DIS_RES_X = 240,
   parameter int DIS_RES_Y = 320,
   parameter int PATTERN   = 0,
   parameter int FRAME_GAP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        pix_ready,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_eof,
   output logic [7:0]  frame_count
);

   localparam int XW       = $clog2(DIS_RES_X);
   localparam int YW       = $clog2(DIS_RES_Y);
   localparam int BAR_W    = (DIS_RES_X / 8 > 0) ? DIS_RES_X / 8 : 1;
   localparam int GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam int GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;
   localparam logic [XW-1:0] X_LAST   = XW'(DIS_RES_X - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(DIS_RES_Y - 1);
   localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
   localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

   typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

   state_t           state_q, state_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [XW-1:0]    ex_q, ex_d;
   logic [XW+2:0]    bar_q, bar_d;
   logic [XW-1:0]    off_q, off_d;
   logic [XW+2:0]    off_bar_q, off_bar_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [7:0]       fc_q, fc_d;
   logic             valid_q, valid_d;
   logic [15:0]      data_q, data_d;
   logic             sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
   logic             load;

   // Bar state is {bar index, position within bar}; the index saturates at 7.
   function automatic logic [XW+2:0] bar_step(input logic [XW+2:0] cur);
      logic [2:0]    idx;
      logic [XW-1:0] cnt;
      idx = cur[XW+2:XW];
      cnt = cur[XW-1:0];
      if (cnt == BAR_LAST) begin
         cnt = '0;
         if (idx != 3'd7) idx = idx + 3'd1;
      end else begin
         cnt = cnt + 1'b1;
      end
      return {idx, cnt};
   endfunction

   // Advances the effective (possibly scrolled) column together with its bar state.
   function automatic logic [2*XW+2:0] col_step(input logic [XW-1:0] ex,
                                                input logic [XW+2:0] bar);
      if (ex == X_LAST) return '0;
      return {ex + 1'b1, bar_step(bar)};
   endfunction

   function automatic logic [15:0] colour(input logic [XW-1:0] ex, input logic [YW-1:0] y,
                                          input logic [2:0] idx);
      if (PATTERN == 1) begin
         case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
         endcase
      end else if (PATTERN == 2) begin
         return (1'(ex >> 3) ^ 1'(y >> 3)) ? 16'h0000 : 16'hFFFF;
      end
      return 16'hF800;
   endfunction

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      ex_d      = ex_q;
      bar_d     = bar_q;
      off_d     = off_q;
      off_bar_d = off_bar_q;
      gap_d     = gap_q;
      fc_d      = fc_q;
      valid_d   = valid_q;
      data_d    = data_q;
      sof_d     = sof_q;
      eol_d     = eol_q;
      eof_d     = eof_q;
      load      = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = STREAM;
               x_d     = '0;
               y_d     = '0;
               ex_d    = off_q;
               bar_d   = off_bar_q;
               load    = 1'b1;
            end
         end
         STREAM: begin
            if (pix_ready) begin
               if (eof_q) begin
                  valid_d = 1'b0;
                  data_d  = '0;
                  sof_d   = 1'b0;
                  eol_d   = 1'b0;
                  eof_d   = 1'b0;
                  fc_d    = fc_q + 8'd1;
                  gap_d   = '0;
                  state_d = (FRAME_GAP == 0) ? IDLE : GAP;
`ifdef PIXEL_PATTERN_ANIMATE_EN
                  // Scroll offset tracks frame_count modulo DIS_RES_X, including the 255->0 wrap.
                  if (fc_d == '0) {off_d, off_bar_d} = '0;
                  else            {off_d, off_bar_d} = col_step(off_q, off_bar_q);
`endif
               end else if (x_q == X_LAST) begin
                  x_d   = '0;
                  y_d   = y_q + 1'b1;
                  ex_d  = off_q;
                  bar_d = off_bar_q;
                  load  = 1'b1;
               end else begin
                  x_d           = x_q + 1'b1;
                  {ex_d, bar_d} = col_step(ex_q, bar_q);
                  load          = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_END) state_d = IDLE;
            else                  gap_d   = gap_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         valid_d = 1'b1;
         data_d  = colour(ex_d, y_d, bar_d[XW+2:XW]);
         sof_d   = (x_d == '0) && (y_d == '0);
         eol_d   = (x_d == X_LAST);
         eof_d   = (x_d == X_LAST) && (y_d == Y_LAST);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         ex_q      <= '0;
         bar_q     <= '0;
         off_q     <= '0;
         off_bar_q <= '0;
         gap_q     <= '0;
         fc_q      <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         sof_q     <= 1'b0;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         ex_q      <= ex_d;
         bar_q     <= bar_d;
         off_q     <= off_d;
         off_bar_q <= off_bar_d;
         gap_q     <= gap_d;
         fc_q      <= fc_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         sof_q     <= sof_d;
         eol_q     <= eol_d;
         eof_q     <= eof_d;
      end
   end

   assign pix_valid   = valid_q;
   assign pix_data    = data_q;
   assign pix_sof     = sof_q;
   assign pix_eol     = eol_q;
   assign pix_eof     = eof_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_pixel_pattern_source.sv
// Scoreboard bench for pixel_pattern_source: three instances (solid 4x3, bars 16x2, checker 16x10).
module tb_pixel_pattern_source;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  en    = '0;
   logic [2:0]  rdy   = '0;
   logic [2:0]  pv, sof, eol, eof;
   logic [15:0] pd [3];
   logic [7:0]  fc [3];

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] d;
      logic        s;
      logic        l;
      logic        e;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   pixel_pattern_source #(.DIS_RES_X(4), .DIS_RES_Y(3), .PATTERN(0), .FRAME_GAP(4)) u_dut_a (
      .clk(clk), .reset(reset), .enable(en[0]), .pix_ready(rdy[0]), .pix_valid(pv[0]),
      .pix_data(pd[0]), .pix_sof(sof[0]), .pix_eol(eol[0]), .pix_eof(eof[0]), .frame_count(fc[0]));

   pixel_pattern_source #(.DIS_RES_X(16), .DIS_RES_Y(2), .PATTERN(1), .FRAME_GAP(0)) u_dut_b (
      .clk(clk), .reset(reset), .enable(en[1]), .pix_ready(rdy[1]), .pix_valid(pv[1]),
      .pix_data(pd[1]), .pix_sof(sof[1]), .pix_eol(eol[1]), .pix_eof(eof[1]), .frame_count(fc[1]));

   pixel_pattern_source #(.DIS_RES_X(16), .DIS_RES_Y(10), .PATTERN(2), .FRAME_GAP(1)) u_dut_c (
      .clk(clk), .reset(reset), .enable(en[2]), .pix_ready(rdy[2]), .pix_valid(pv[2]),
      .pix_data(pd[2]), .pix_sof(sof[2]), .pix_eol(eol[2]), .pix_eof(eof[2]), .frame_count(fc[2]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int res_x(input int g);
      return (g == 0) ? 4 : 16;
   endfunction

   function automatic int res_y(input int g);
      return (g == 0) ? 3 : ((g == 1) ? 2 : 10);
   endfunction

   function automatic logic [15:0] model_pix(input int g, input int x, input int y, input int fr);
      int ex, bw, idx;
      ex = x;
`ifdef PIXEL_PATTERN_ANIMATE_EN
      if (g != 0) ex = (x + (fr % 256)) % res_x(g);
`endif
      if (g == 1) begin
         bw  = (res_x(g) / 8 > 0) ? res_x(g) / 8 : 1;
         idx = ex / bw;
         if (idx > 7) idx = 7;
         case (idx)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
         endcase
      end else if (g == 2) begin
         return (((ex / 8) % 2) != ((y / 8) % 2)) ? 16'h0000 : 16'hFFFF;
      end
      return (fr >= 0) ? 16'hF800 : 16'hF800;
   endfunction

   task automatic push_frame(input int g, input int fr);
      exp_t e;
      for (int y = 0; y < res_y(g); y++) begin
         for (int x = 0; x < res_x(g); x++) begin
            e.d = model_pix(g, x, y, fr);
            e.s = (x == 0) && (y == 0);
            e.l = (x == res_x(g) - 1);
            e.e = (x == res_x(g) - 1) && (y == res_y(g) - 1);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A transfer happens on the posedge following a negedge where valid and ready are both high.
   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < 3; g++) begin
         if (pv[g] && rdy[g]) begin
            if (sbq.size() == 0) begin
               check_eq($sformatf("unexpected_xfer%0d", g), {30'd0, pv[g], rdy[g]}, 32'd0);
            end else begin
               e = sbq.pop_front();
               check_eq($sformatf("pix%0d", g), {13'd0, pd[g], sof[g], eol[g], eof[g]}, {13'd0, e});
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      #1 reset = 1'b1;
      #1;
      check_eq("rst_valid", {31'd0, pv[0]}, 32'd0);
      check_eq("rst_data",  {16'd0, pd[0]}, 32'd0);
      check_eq("rst_flags", {29'd0, sof[0], eol[0], eof[0]}, 32'd0);
      check_eq("rst_fc",    {24'd0, fc[0]}, 32'd0);
      step();
      step();
      reset = 1'b0;

      // Instance A: two frames back to back with a stall in frame 0.
      push_frame(0, 0);
      push_frame(0, 1);
      en[0]  = 1'b1;
      rdy[0] = 1'b1;
      n = 0;
      while (!(pv[0] && sbq.size() == 23) && n < 100) begin step(); n++; end
      check_eq("wait_stall", {31'd0, n < 100}, 32'd1);
      rdy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("stall_hold", {12'd0, pv[0], pd[0], sof[0], eol[0], eof[0]}, {12'd0, 1'b1, sbq[0]});
      end
      rdy[0] = 1'b1;

      n = 0;
      while (!(!pv[0] && sbq.size() == 12) && n < 100) begin step(); n++; end
      check_eq("wait_eof", {31'd0, n < 100}, 32'd1);
      n = 0;
      while (!pv[0] && n < 20) begin n++; step(); end
      check_eq("gap_cycles", n, 32'd5);
      en[0] = 1'b0;

      n = 0;
      while (!(sbq.size() == 0 && !pv[0]) && n < 100) begin step(); n++; end
      check_eq("wait_done_a", {31'd0, n < 100}, 32'd1);
      repeat (10) step();
      check_eq("fc_a", {24'd0, fc[0]}, 32'd2);
      check_eq("idle_a", {31'd0, pv[0]}, 32'd0);

      // Instance A: reset while pixel (2,1) is presented, then restart from (0,0).
      push_frame(0, 2);
      en[0] = 1'b1;
      n = 0;
      while (!(pv[0] && sbq.size() == 6) && n < 100) begin step(); n++; end
      check_eq("wait_px21", {31'd0, n < 100}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", {31'd0, pv[0]}, 32'd0);
      check_eq("mid_rst_data",  {16'd0, pd[0]}, 32'd0);
      check_eq("mid_rst_flags", {29'd0, sof[0], eol[0], eof[0]}, 32'd0);
      check_eq("mid_rst_fc",    {24'd0, fc[0]}, 32'd0);
      step();
      step();
      sbq.delete();
      push_frame(0, 0);
      reset = 1'b0;
      step();
      check_eq("restart_sof", {31'd0, sof[0]}, 32'd1);
      en[0] = 1'b0;
      n = 0;
      while (!(sbq.size() == 0 && !pv[0]) && n < 100) begin step(); n++; end
      check_eq("wait_restart", {31'd0, n < 100}, 32'd1);
      check_eq("fc_restart", {24'd0, fc[0]}, 32'd1);
      rdy[0] = 1'b0;

      // Instance B: colour bars, three frames, enable dropped during the last one.
      for (int f = 0; f < 3; f++) push_frame(1, f);
      en[1]  = 1'b1;
      rdy[1] = 1'b1;
      n = 0;
      while (!(sbq.size() < 32) && n < 400) begin step(); n++; end
      check_eq("wait_last_b", {31'd0, n < 400}, 32'd1);
      en[1] = 1'b0;
      n = 0;
      while (!(sbq.size() == 0 && !pv[1]) && n < 400) begin step(); n++; end
      check_eq("wait_done_b", {31'd0, n < 400}, 32'd1);
      repeat (5) step();
      check_eq("fc_b", {24'd0, fc[1]}, 32'd3);
      rdy[1] = 1'b0;

      // Instance C: checkerboard, two frames.
      for (int f = 0; f < 2; f++) push_frame(2, f);
      en[2]  = 1'b1;
      rdy[2] = 1'b1;
      n = 0;
      while (!(sbq.size() < 160) && n < 1000) begin step(); n++; end
      check_eq("wait_last_c", {31'd0, n < 1000}, 32'd1);
      en[2] = 1'b0;
      n = 0;
      while (!(sbq.size() == 0 && !pv[2]) && n < 1000) begin step(); n++; end
      check_eq("wait_done_c", {31'd0, n < 1000}, 32'd1);
      repeat (5) step();
      check_eq("fc_c", {24'd0, fc[2]}, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
